// File: rtl/kmp_pe_pkg.sv
// Shared widths, types and pattern helpers for the KMP processing element.
package kmp_pe_pkg;

    localparam int MAX_STR_ADD = 5;
    localparam int MAX_PAT_ADD = 3;
    localparam int CHAR_W      = 8;
    localparam int PAT_LEN     = 1 << MAX_PAT_ADD;
    localparam int PAT_W       = CHAR_W * PAT_LEN;

    typedef logic [CHAR_W-1:0]      char_t;
    typedef logic [PAT_W-1:0]       pat_t;
    typedef logic [MAX_PAT_ADD-1:0] pidx_t;
    typedef logic [MAX_PAT_ADD:0]   pcnt_t;
    typedef logic [MAX_STR_ADD-1:0] sidx_t;
    typedef logic [MAX_STR_ADD:0]   icnt_t;

    function automatic char_t pat_char(input pat_t pat, input pidx_t idx);
        return pat[idx*CHAR_W +: CHAR_W];
    endfunction

endpackage

// File: rtl/kmp_pe_if.sv
// Job/result and string-read signals between the KMP controller and one PE.
interface kmp_pe_if;
    import kmp_pe_pkg::*;

    logic  pe_valid;
    sidx_t start_idx;
    sidx_t process_2idx;
    pidx_t pat_last_idx;
    pat_t  pattern;
    sidx_t str_rd_addr;
    char_t str_rd_data;
    logic  match_valid;
    logic  match;
    sidx_t match_idx;

    modport master (
        output pe_valid, start_idx, process_2idx, pat_last_idx, pattern, str_rd_data,
        input  str_rd_addr, match_valid, match, match_idx
    );

    modport slave (
        input  pe_valid, start_idx, process_2idx, pat_last_idx, pattern, str_rd_data,
        output str_rd_addr, match_valid, match, match_idx
    );
endinterface

// File: rtl/kmp_fail_table.sv
// Builds the KMP failure table pi[] one step per cycle and serves one read port.
module kmp_fail_table
    import kmp_pe_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  start,
    input  logic  clear,
    input  pat_t  pattern,
    input  pidx_t pat_last_idx,
    output logic  done,
    input  pidx_t rd_idx,
    output pidx_t rd_pi
);
    logic  running_q, running_d;
    pcnt_t k_q, k_d;
    pcnt_t q_q, q_d;
    pidx_t pi_q [PAT_LEN];
    pidx_t pi_d [PAT_LEN];

    pcnt_t last_ext;
    pidx_t q_lo, k_lo;
    logic  chars_eq;

    assign last_ext = pcnt_t'(pat_last_idx);
    assign q_lo     = pidx_t'(q_q);
    assign k_lo     = pidx_t'(k_q);
    assign chars_eq = (pat_char(pattern, q_lo) == pat_char(pattern, k_lo));
    assign done     = running_q && (q_q > last_ext);
    assign rd_pi    = pi_q[rd_idx];

    always_comb begin
        running_d = running_q;
        k_d       = k_q;
        q_d       = q_q;
        for (int n = 0; n < PAT_LEN; n++) begin
            pi_d[n] = pi_q[n];
        end

        if (clear) begin
            running_d = 1'b0;
        end else if (start) begin
            running_d = 1'b1;
            k_d       = '0;
            q_d       = pcnt_t'(1);
            pi_d[0]   = '0;
        end else if (running_q && !done) begin
            if (chars_eq) begin
                pi_d[q_lo] = k_lo + pidx_t'(1);
                k_d        = k_q + pcnt_t'(1);
                q_d        = q_q + pcnt_t'(1);
            end else if (k_q != '0) begin
                // Fall back to the longest proper border of P[0..k-1]
                k_d = pcnt_t'(pi_q[k_lo - pidx_t'(1)]);
            end else begin
                pi_d[q_lo] = '0;
                q_d        = q_q + pcnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            running_q <= 1'b0;
            k_q       <= '0;
            q_q       <= '0;
            for (int n = 0; n < PAT_LEN; n++) begin
                pi_q[n] <= '0;
            end
        end else begin
            running_q <= running_d;
            k_q       <= k_d;
            q_q       <= q_d;
            for (int n = 0; n < PAT_LEN; n++) begin
                pi_q[n] <= pi_d[n];
            end
        end
    end

endmodule

// File: rtl/kmp_pe.sv
// KMP processing element: latches a job, builds pi[], scans the slice [S,E].
module kmp_pe
    import kmp_pe_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    kmp_pe_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FAIL = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;
    sidx_t  s_q, s_d;
    sidx_t  e_q, e_d;
    pidx_t  l_q, l_d;
    pat_t   p_q, p_d;
    icnt_t  i_q, i_d;
    pidx_t  j_q, j_d;
    logic   match_valid_q, match_valid_d;
    logic   match_q, match_d;
    sidx_t  match_idx_q, match_idx_d;

    logic   ft_start, ft_clear, ft_done;
    pidx_t  ft_rd_pi;
    logic   char_hit;

    kmp_fail_table u_fail_table (
        .clk          (clk),
        .reset        (reset),
        .start        (ft_start),
        .clear        (ft_clear),
        .pattern      (p_q),
        .pat_last_idx (l_q),
        .done         (ft_done),
        .rd_idx       (j_q - pidx_t'(1)),
        .rd_pi        (ft_rd_pi)
    );

    assign char_hit        = (bus.str_rd_data == pat_char(p_q, j_q));
    assign bus.str_rd_addr = sidx_t'(i_q);
    assign bus.match_valid = match_valid_q;
    assign bus.match       = match_q;
    assign bus.match_idx   = match_idx_q;

    always_comb begin
        state_d       = state_q;
        s_d           = s_q;
        e_d           = e_q;
        l_d           = l_q;
        p_d           = p_q;
        i_d           = i_q;
        j_d           = j_q;
        match_valid_d = match_valid_q;
        match_d       = match_q;
        match_idx_d   = match_idx_q;
        ft_start      = 1'b0;
        ft_clear      = 1'b0;

        if (!bus.pe_valid) begin
            // Withdrawal aborts any job and ends a completed one
            state_d       = ST_IDLE;
            i_d           = '0;
            j_d           = '0;
            match_valid_d = 1'b0;
            match_d       = 1'b0;
            match_idx_d   = '0;
            ft_clear      = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    s_d = bus.start_idx;
                    e_d = bus.process_2idx;
                    l_d = bus.pat_last_idx;
                    p_d = bus.pattern;
                    j_d = '0;
                    if (bus.pat_last_idx == '0) begin
                        state_d = ST_SCAN;
                        i_d     = icnt_t'(bus.start_idx);
                    end else begin
                        state_d  = ST_FAIL;
                        ft_start = 1'b1;
                    end
                end
                ST_FAIL: begin
                    if (ft_done) begin
                        state_d  = ST_SCAN;
                        ft_clear = 1'b1;
                        i_d      = icnt_t'(s_q);
                        j_d      = '0;
                    end
                end
                ST_SCAN: begin
                    // i is one bit wider than the address so E=max terminates cleanly
                    if (i_q > icnt_t'(e_q)) begin
                        state_d       = ST_DONE;
                        match_valid_d = 1'b1;
                        match_d       = 1'b0;
                        match_idx_d   = '0;
                    end else if (char_hit && (j_q == l_q)) begin
                        state_d       = ST_DONE;
                        match_valid_d = 1'b1;
                        match_d       = 1'b1;
                        match_idx_d   = sidx_t'(i_q - icnt_t'(l_q));
                    end else if (char_hit) begin
                        i_d = i_q + icnt_t'(1);
                        j_d = j_q + pidx_t'(1);
                    end else if (j_q != '0) begin
                        j_d = ft_rd_pi;
                    end else begin
                        i_d = i_q + icnt_t'(1);
                    end
                end
                default: begin
                    match_valid_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            s_q           <= '0;
            e_q           <= '0;
            l_q           <= '0;
            p_q           <= '0;
            i_q           <= '0;
            j_q           <= '0;
            match_valid_q <= 1'b0;
            match_q       <= 1'b0;
            match_idx_q   <= '0;
        end else begin
            state_q       <= state_d;
            s_q           <= s_d;
            e_q           <= e_d;
            l_q           <= l_d;
            p_q           <= p_d;
            i_q           <= i_d;
            j_q           <= j_d;
            match_valid_q <= match_valid_d;
            match_q       <= match_d;
            match_idx_q   <= match_idx_d;
        end
    end

endmodule
